// File: rtl/bcd_multiplier_digit_sequencer.sv
// bcd_multiplier_digit_sequencer
// Walks an N-digit BCD multiplier LSD first, recodes each digit (plus the
// running carry) into a signed digit -5..+4, and hands the one-hot magnitude
// (yi) and sign (ysi) to the partial-product accumulator over a valid/ready
// handshake. N_DIGITS+1 digits are issued; the last one is the recoding carry.
// Optional build macro: SKIP_ZERO_EN -- zero-valued digits are stepped over
// without a handshake (pp_valid stays low for that cycle).
// All outputs decode from registered state only; no input reaches an output
// combinationally.

module bcd_multiplier_digit_sequencer #(
  parameter int N_DIGITS = 4,
  localparam int IDX_W = $clog2(N_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4*N_DIGITS-1:0]   multiplier,
  output logic                    busy,
  output logic                    pp_valid,
  input  logic                    pp_ready,
  output logic [5:1]              yi,
  output logic                    ysi,
  output logic [IDX_W-1:0]        pp_index,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS);

  // Recode one digit with incoming carry: returns {carry_next, neg, mag[2:0]}.
  // v = d + c; v >= 5 maps to v - 10 (negative, or zero for v == 10) with carry.
  function automatic logic [4:0] recode(input logic [3:0] d, input logic c);
    logic [4:0] v;
    logic [4:0] res;
    v = {1'b0, d} + {4'd0, c};
    if (v >= 5'd5) begin
      res[4]   = 1'b1;
      res[3]   = (v != 5'd10);
      res[2:0] = 3'(5'd10 - v);
    end else begin
      res[4]   = 1'b0;
      res[3]   = 1'b0;
      res[2:0] = v[2:0];
    end
    return res;
  endfunction

  // Operand check: flags any nibble that is not a legal BCD digit.
  function automatic logic has_bad_digit(input logic [4*N_DIGITS-1:0] m);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      bad = bad | (m[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  state_t                  state_r;
  state_t                  state_s;
  logic [4*N_DIGITS-1:0]   digits_r;
  logic                    carry_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    err_r;

  logic [4:0]              rec_s;
  logic [2:0]              mag_s;
  logic                    neg_s;
  logic                    carry_next_s;
  logic [5:1]              yi_s;
  logic                    issue_s;
  logic                    adv_s;
  logic                    last_s;
  logic                    bad_s;
`ifdef SKIP_ZERO_EN
  logic                    zero_s;
`endif

  // Recode the current digit (the shift register's low nibble; zero past the MSD).
  always_comb begin
    rec_s        = recode(digits_r[3:0], carry_r);
    carry_next_s = rec_s[4];
    neg_s        = rec_s[3];
    mag_s        = rec_s[2:0];
    bad_s        = has_bad_digit(multiplier);
    last_s       = (idx_r == LAST_IDX);
  end

  // One-hot magnitude decode: bit k set when |digit| == k, all zero for 0.
  always_comb begin
    yi_s = 5'b00000;
    case (mag_s)
      3'd1:    yi_s = 5'b00001;
      3'd2:    yi_s = 5'b00010;
      3'd3:    yi_s = 5'b00100;
      3'd4:    yi_s = 5'b01000;
      3'd5:    yi_s = 5'b10000;
      default: yi_s = 5'b00000;
    endcase
  end

  // Decide whether the current digit is offered and whether it retires this cycle.
  always_comb begin
`ifdef SKIP_ZERO_EN
    zero_s  = (mag_s == 3'd0);
    issue_s = (state_r == ISSUE) && !zero_s;
    adv_s   = (state_r == ISSUE) && (zero_s || pp_ready);
`else
    issue_s = (state_r == ISSUE);
    adv_s   = issue_s && pp_ready;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (bad_s) begin
            state_s = FIN;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (adv_s && last_s) begin
          state_s = FIN;
        end else begin
          state_s = ISSUE;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, digit shift, carry and weight counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r <= '0;
      carry_r  <= 1'b0;
      idx_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            digits_r <= multiplier;
            carry_r  <= 1'b0;
            idx_r    <= '0;
            err_r    <= bad_s;
          end else begin
            digits_r <= digits_r;
            carry_r  <= carry_r;
            idx_r    <= idx_r;
            err_r    <= err_r;
          end
        end
        ISSUE: begin
          if (adv_s) begin
            digits_r <= digits_r >> 4'd4;
            carry_r  <= carry_next_s;
            idx_r    <= last_s ? '0 : (idx_r + IDX_W'(1));
          end else begin
            digits_r <= digits_r;
            carry_r  <= carry_r;
            idx_r    <= idx_r;
          end
          err_r <= err_r;
        end
        FIN: begin
          digits_r <= '0;
          carry_r  <= 1'b0;
          idx_r    <= '0;
          err_r    <= 1'b0;
        end
        default: begin
          digits_r <= '0;
          carry_r  <= 1'b0;
          idx_r    <= '0;
          err_r    <= 1'b0;
        end
      endcase
    end
  end

  // FSM outputs, decoded from state and datapath registers only.
  always_comb begin
    busy     = 1'b0;
    pp_valid = 1'b0;
    yi       = 5'b00000;
    ysi      = 1'b0;
    pp_index = '0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      ISSUE: begin
        busy     = 1'b1;
        pp_valid = issue_s;
        yi       = yi_s;
        ysi      = neg_s;
        pp_index = idx_r;
      end
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
        err  = err_r;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_multiplier_digit_sequencer.sv
// Self-checking bench for bcd_multiplier_digit_sequencer: directed operands
// from the test plan plus randomized operands and back-pressure, checked
// against an integer-arithmetic reference of the signed-digit recoding and a
// reconstruction of the multiplier value from the issued digits.
// Honours SKIP_ZERO_EN the same way the design does.

module tb_bcd_multiplier_digit_sequencer;

  localparam int N     = 4;
  localparam int IDX_W = $clog2(N + 1);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [4*N-1:0]   multiplier;
  logic             busy;
  logic             pp_valid;
  logic             pp_ready;
  logic [5:1]       yi;
  logic             ysi;
  logic [IDX_W-1:0] pp_index;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  bcd_multiplier_digit_sequencer #(.N_DIGITS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .multiplier (multiplier),
    .busy       (busy),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .yi         (yi),
    .ysi        (ysi),
    .pp_index   (pp_index),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:1] onehot(input int mag);
    logic [5:1] r;
    r = 5'b00000;
    if (mag > 0) r = 5'b00001 << (mag - 1);
    return r;
  endfunction

  function automatic longint pow10(input int e);
    longint p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  // Expected transfers for one operand: weights and signed values, LSD first.
  int     exp_idx[$];
  int     exp_val[$];
  bit     exp_bad;
  longint exp_dec;

  task automatic build_model(input logic [4*N-1:0] m);
    int c;
    int d;
    int v;
    int val;
    exp_idx.delete();
    exp_val.delete();
    exp_bad = 1'b0;
    exp_dec = 0;
    c = 0;
    for (int i = 0; i <= N; i++) begin
      d = (i < N) ? int'(m[4*i +: 4]) : 0;
      if (d > 9) exp_bad = 1'b1;
      if (i < N) exp_dec = exp_dec + longint'(d) * pow10(i);
      v = d + c;
      if (v >= 5) begin
        val = v - 10;
        c = 1;
      end else begin
        val = v;
        c = 0;
      end
`ifdef SKIP_ZERO_EN
      if (val != 0) begin
        exp_idx.push_back(i);
        exp_val.push_back(val);
      end
`else
      exp_idx.push_back(i);
      exp_val.push_back(val);
`endif
    end
    if (exp_bad) begin
      exp_idx.delete();
      exp_val.delete();
    end
  endtask

  // One operation. Caller is at a negedge with the DUT idle.
  // mode 0: ready always 1; mode 1: random ready; mode 2: 3-cycle stall at idx2.
  task automatic run_op(input logic [4*N-1:0] m, input int mode);
    int         cyc;
    int         stall;
    bit         fin;
    bit         r;
    bit         prev_stall;
    logic [5:1] prev_yi;
    logic       prev_ysi;
    logic [IDX_W-1:0] prev_idx;
    longint     sum;
    int         mag;
    int         val;
    build_model(m);
    multiplier = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    multiplier = 16'($urandom);
    cyc = 0;
    stall = 0;
    fin = 1'b0;
    prev_stall = 1'b0;
    prev_yi = 5'b00000;
    prev_ysi = 1'b0;
    prev_idx = '0;
    sum = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      chk("busy_active", busy, 1'b1);
      if (prev_stall) begin
        chk("stall_valid", pp_valid, 1'b1);
        chk("stall_yi", yi, prev_yi);
        chk("stall_ysi", ysi, prev_ysi);
        chk("stall_idx", pp_index, prev_idx);
      end
      if (pp_valid) begin
        chk("valid_expected", exp_idx.size() > 0, 1'b1);
        if (exp_idx.size() > 0) begin
          chk("pp_index", pp_index, exp_idx[0]);
          chk("yi", yi, onehot(exp_val[0] < 0 ? -exp_val[0] : exp_val[0]));
          chk("ysi", ysi, exp_val[0] < 0);
        end
      end
      if (done) begin
        fin = 1'b1;
        chk("err", err, exp_bad);
        chk("left_over", exp_idx.size(), 0);
        if (mode == 0) chk("done_latency", cyc, exp_bad ? 1 : N + 2);
        if (!exp_bad) chk("value", sum, exp_dec);
      end
      if (mode == 0) begin
        r = 1'b1;
      end else if (mode == 1) begin
        r = 1'($urandom_range(0, 1));
      end else begin
        r = 1'b1;
        if (pp_valid && pp_index == 2 && stall < 3) begin
          r = 1'b0;
          stall++;
        end
      end
      pp_ready = r;
      if (pp_valid && r) begin
        mag = 0;
        for (int k = 1; k <= 5; k++) if (yi[k]) mag = k;
        val = ysi ? -mag : mag;
        sum = sum + longint'(val) * pow10(int'(pp_index));
        if (exp_idx.size() > 0) begin
          void'(exp_idx.pop_front());
          void'(exp_val.pop_front());
        end
      end
      prev_stall = pp_valid && !r;
      prev_yi = yi;
      prev_ysi = ysi;
      prev_idx = pp_index;
    end
    if (!fin) chk("done_timeout", 1'b0, 1'b1);
    if (mode == 2) chk("stall_cycles", stall, 3);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_valid", pp_valid, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_valid"}, pp_valid, 1'b0);
    chk({tag, "_yi"}, yi, 5'b00000);
    chk({tag, "_ysi"}, ysi, 1'b0);
    chk({tag, "_idx"}, pp_index, 0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    logic [4*N-1:0] m;
    rst_n = 1'b0;
    start = 1'b0;
    multiplier = '0;
    pp_ready = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 0);
    run_op(16'h0789, 0);
    run_op(16'h0005, 0);
    run_op(16'h9999, 0);
    run_op(16'h0000, 0);
    run_op(16'h00A1, 0);
    run_op(16'h1234, 2);

    // Abort mid-sequence with an asynchronous reset.
    multiplier = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_done", done, 1'b0);
      chk("abort_busy", busy, 1'b0);
    end
    rst_n = 1'b1;
    run_op(16'h1234, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) m[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) m[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
      run_op(m, int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
